// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin owner of the shared 8-bit ALU with compare/branch locking; `ALU_ARB_STATS_EN adds an op counter
module alu_share_arb #(
  parameter int NREQ = 2,
  parameter int LOCK_MAX = 15,
  parameter logic [4:0] IDLE_OP = 5'b00011
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [8*NREQ-1:0]  req_a,
  input  logic [8*NREQ-1:0]  req_b,
  input  logic [5*NREQ-1:0]  req_op,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [15:0]        rsp_rslt,
  output logic               rsp_branch,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [4:0]         alu_op,
  input  logic [15:0]        alu_rslt,
  input  logic               alu_branch,
  output logic [15:0]        op_count
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2, LOCKED = 2'd3;
  logic [1:0] state;
  logic [PW-1:0] rr_ptr, owner, pick, sel, nxt_owner;
  logic [7:0] a_q, b_q, idle_cnt;
  logic [4:0] op_q;
  logic lock_q, hs, rsp_acc;
  // first valid requester at or after rr_ptr, cyclically
  always_comb begin
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) pick = PW'((int'(rr_ptr) + k) % NREQ);
  end
  // grant: rotating pick in IDLE, only the lock owner in LOCKED, nobody otherwise
  always_comb begin
    req_ready = '0;
    if (state == IDLE && |req_valid) req_ready[pick] = 1'b1;
    else if (state == LOCKED) req_ready[owner] = req_valid[owner];
  end
  assign hs = |req_ready;
  assign sel = state == IDLE ? pick : owner;
  assign nxt_owner = PW'((int'(owner) + 1) % NREQ);
  assign rsp_acc = state == RESP && rsp_ready[owner];
  assign rsp_valid = state == RESP ? {{(NREQ-1){1'b0}}, 1'b1} << owner : '0;
  assign alu_op = state == EXEC ? op_q : IDLE_OP;
  assign alu_a = state == EXEC ? a_q : 8'h00;
  assign alu_b = state == EXEC ? b_q : 8'h00;
  // sequencer: accept -> one ALU cycle -> hold response -> release or keep the lock
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      lock_q <= 1'b0;
      idle_cnt <= '0;
      rsp_rslt <= '0;
      rsp_branch <= 1'b0;
    end else if (hs) begin
      a_q <= req_a[8*sel +: 8];
      b_q <= req_b[8*sel +: 8];
      op_q <= req_op[5*sel +: 5];
      lock_q <= req_lock[sel];
      owner <= sel;
      state <= EXEC;
    end else if (state == EXEC) begin
      rsp_rslt <= alu_rslt;
      rsp_branch <= alu_branch;
      state <= RESP;
    end else if (rsp_acc) begin
      state <= lock_q ? LOCKED : IDLE;
      idle_cnt <= '0;
      if (!lock_q) rr_ptr <= nxt_owner;
    end else if (state == LOCKED) begin
      idle_cnt <= idle_cnt + 8'd1;
      if (idle_cnt == 8'(LOCK_MAX - 1)) begin
        state <= IDLE;
        rr_ptr <= nxt_owner;
      end
    end
  end
`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt_q;
  // completed operations, saturating
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else if (rsp_acc && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign op_count = cnt_q;
`else
  assign op_count = '0;
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed checks of alu_share_arb with a small flag-keeping ALU model
module tb_alu_share_arb;
  localparam logic [4:0] ADD = 5'd0, XOR = 5'd2, COPY = 5'd3, CMP = 5'd4, BLT = 5'd5;
  logic Clk = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = '0, req_ready, req_lock = '0, rsp_valid, rsp_ready = '0;
  logic [15:0] req_a = '0, req_b = '0, rsp_rslt, alu_rslt, op_count;
  logic [9:0] req_op = '0;
  logic rsp_branch, alu_branch, lt_flag = 1'b0;
  logic [7:0] alu_a, alu_b;
  logic [4:0] alu_op;
  int checks = 0, errors = 0;

  alu_share_arb #(.NREQ(2), .LOCK_MAX(15), .IDLE_OP(5'b00011)) dut (
    .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rslt(rsp_rslt), .rsp_branch(rsp_branch), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_rslt(alu_rslt), .alu_branch(alu_branch), .op_count(op_count));

  always #5 Clk = ~Clk;

  assign alu_rslt = alu_op == ADD ? {8'h00, alu_a} + {8'h00, alu_b} :
                    alu_op == XOR ? {8'h00, alu_a ^ alu_b} :
                    alu_op == COPY ? {8'h00, alu_a} : 16'h0000;
  assign alu_branch = alu_op == BLT && lt_flag;
  always @(posedge Clk) if (alu_op == CMP) lt_flag <= alu_a < alu_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge Clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [4:0] op, input logic l);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_op[5*i +: 5] = op;
    req_lock[i] = l;
  endtask

  task automatic do_reset;
    req_valid = '0;
    req_lock = '0;
    rsp_ready = '0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, bad;
    repeat (2) tick;
    reset = 1'b0;
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rslt", rsp_rslt, 16'h0000);
    chk("rst_branch", rsp_branch, 1'b0);
    chk("rst_alu_op", alu_op, 5'b00011);
    chk("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
    chk("rst_op_count", op_count, 16'h0000);
    // single Add
    set_req(0, 8'h7F, 8'h01, ADD, 1'b0);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    #1 chk("t1_ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    #1 chk("t1_exec_op", alu_op, ADD);
    chk("t1_exec_a", alu_a, 8'h7F);
    chk("t1_exec_ready", req_ready, 2'b00);
    chk("t1_exec_rv", rsp_valid, 2'b00);
    tick;
    #1 chk("t1_rv", rsp_valid, 2'b01);
    chk("t1_rslt", rsp_rslt, 16'h0080);
    chk("t1_resp_op", alu_op, 5'b00011);
    tick;
    #1 chk("t1_done_rv", rsp_valid, 2'b00);
    // contention: both request Xor continuously
    do_reset;
    set_req(0, 8'h0F, 8'hF0, XOR, 1'b0);
    set_req(1, 8'h3C, 8'h0F, XOR, 1'b0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("ct%0d_ready", i), req_ready, (i % 2) ? 2'b10 : 2'b01);
      tick;
      tick;
      #1 chk($sformatf("ct%0d_rv", i), rsp_valid, (i % 2) ? 2'b10 : 2'b01);
      chk($sformatf("ct%0d_rslt", i), rsp_rslt, (i % 2) ? 16'h0033 : 16'h00FF);
      tick;
    end
    // locked compare then branch by requester 1 while requester 0 waits
    do_reset;
    rsp_ready = 2'b11;
    set_req(1, 8'd3, 8'd5, CMP, 1'b1);
    set_req(0, 8'h11, 8'h22, ADD, 1'b0);
    req_valid = 2'b10;
    #1 chk("lk_ready_cmp", req_ready, 2'b10);
    tick;
    req_valid = 2'b11;
    set_req(1, 8'd3, 8'd5, BLT, 1'b0);
    tick;
    #1 chk("lk_cmp_rv", rsp_valid, 2'b10);
    chk("lk_resp_ready", req_ready, 2'b00);
    tick;
    #1 chk("lk_locked_ready", req_ready, 2'b10);
    tick;
    #1 chk("lk_exec_ready", req_ready, 2'b00);
    tick;
    #1 chk("lk_blt_rv", rsp_valid, 2'b10);
    chk("lk_branch", rsp_branch, 1'b1);
    req_valid = 2'b01;
    tick;
    #1 chk("lk_r0_ready", req_ready, 2'b01);
    // lock timeout
    do_reset;
    rsp_ready = 2'b11;
    set_req(0, 8'd3, 8'd5, CMP, 1'b1);
    req_valid = 2'b01;
    #1 chk("to_ready_cmp", req_ready, 2'b01);
    tick;
    req_valid = 2'b10;
    tick;
    tick;
    n = 0;
    #1;
    while (req_ready == 2'b00 && n < 40) begin
      n++;
      tick;
      #1;
    end
    chk("to_locked_cycles", n, 15);
    chk("to_r1_ready", req_ready, 2'b10);
    // backpressure, then reset in RESP
    do_reset;
    set_req(0, 8'h12, 8'h34, ADD, 1'b0);
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    tick;
    bad = 0;
    repeat (10) begin
      #1 if (rsp_valid != 2'b01 || rsp_rslt != 16'h0046) bad++;
      tick;
    end
    chk("bp_unstable_cycles", bad, 0);
    #1 chk("bp_rv", rsp_valid, 2'b01);
    chk("bp_rslt", rsp_rslt, 16'h0046);
    reset = 1'b1;
    #1 chk("rr_rv", rsp_valid, 2'b00);
    chk("rr_alu_op", alu_op, 5'b00011);
    chk("rr_rslt", rsp_rslt, 16'h0000);
    chk("rr_op_count", op_count, 16'h0000);
    tick;
    reset = 1'b0;
    // five completed ops
    do_reset;
    rsp_ready = 2'b11;
    set_req(0, 8'h01, 8'h02, ADD, 1'b0);
    repeat (5) begin
      req_valid = 2'b01;
      tick;
      req_valid = 2'b00;
      tick;
      tick;
    end
`ifdef ALU_ARB_STATS_EN
    #1 chk("stats_count", op_count, 16'd5);
`else
    #1 chk("stats_count", op_count, 16'd0);
`endif
    chk("stats_last_rslt", rsp_rslt, 16'h0003);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
